// File: rtl/nand_serial_logic_unit.sv
// Bit-serial logic unit: NAND, NOT, AND, OR, NOR and XOR rebuilt from one shared
// 2-input NAND evaluator, one micro-step per clock, LSB first.
module nand_serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;

  localparam logic [1:0] SRC_A  = 2'd0;
  localparam logic [1:0] SRC_B  = 2'd1;
  localparam logic [1:0] SRC_T0 = 2'd2;
  localparam logic [1:0] SRC_T1 = 2'd3;

  localparam logic [1:0] DST_T0 = 2'd0;
  localparam logic [1:0] DST_T1 = 2'd1;
  localparam logic [1:0] DST_Y  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, y_r;
  logic             err_r, t0_r, t1_r;
  logic [BW-1:0]    bit_r;
  logic [1:0]       step_r;

  logic [1:0]       src_x_s, src_y_s, dst_s;
  logic             last_s, x_s, z_s, nand_s;

  // The one and only NAND evaluator in the datapath.
  function automatic logic nand2(input logic p, input logic q);
    return ~(p & q);
  endfunction

  function automatic logic pick(input logic [1:0] sel, input logic av, input logic bv,
                                input logic t0v, input logic t1v);
    case (sel)
      SRC_A:   return av;
      SRC_B:   return bv;
      SRC_T0:  return t0v;
      default: return t1v;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] o);
    case (o)
      OP_NAND, OP_NOT, OP_AND, OP_OR, OP_NOR, OP_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Micro-program ROM: operand sources, destination and last-step flag per (op, step).
  always_comb begin
    src_x_s = SRC_A;
    src_y_s = SRC_B;
    dst_s   = DST_Y;
    last_s  = 1'b1;
    case (op_r)
      OP_NAND: begin
        src_x_s = SRC_A;
        src_y_s = SRC_B;
      end
      OP_NOT: begin
        src_x_s = SRC_A;
        src_y_s = SRC_A;
      end
      OP_AND: begin
        case (step_r)
          2'd0:    begin src_x_s = SRC_A;  src_y_s = SRC_B;  dst_s = DST_T0; last_s = 1'b0; end
          default: begin src_x_s = SRC_T0; src_y_s = SRC_T0; dst_s = DST_Y;  last_s = 1'b1; end
        endcase
      end
      OP_OR: begin
        case (step_r)
          2'd0:    begin src_x_s = SRC_A;  src_y_s = SRC_A;  dst_s = DST_T0; last_s = 1'b0; end
          2'd1:    begin src_x_s = SRC_B;  src_y_s = SRC_B;  dst_s = DST_T1; last_s = 1'b0; end
          default: begin src_x_s = SRC_T0; src_y_s = SRC_T1; dst_s = DST_Y;  last_s = 1'b1; end
        endcase
      end
      OP_NOR: begin
        case (step_r)
          2'd0:    begin src_x_s = SRC_A;  src_y_s = SRC_A;  dst_s = DST_T0; last_s = 1'b0; end
          2'd1:    begin src_x_s = SRC_B;  src_y_s = SRC_B;  dst_s = DST_T1; last_s = 1'b0; end
          2'd2:    begin src_x_s = SRC_T0; src_y_s = SRC_T1; dst_s = DST_T0; last_s = 1'b0; end
          default: begin src_x_s = SRC_T0; src_y_s = SRC_T0; dst_s = DST_Y;  last_s = 1'b1; end
        endcase
      end
      OP_XOR: begin
        case (step_r)
          2'd0:    begin src_x_s = SRC_A;  src_y_s = SRC_B;  dst_s = DST_T0; last_s = 1'b0; end
          2'd1:    begin src_x_s = SRC_A;  src_y_s = SRC_T0; dst_s = DST_T1; last_s = 1'b0; end
          2'd2:    begin src_x_s = SRC_B;  src_y_s = SRC_T0; dst_s = DST_T0; last_s = 1'b0; end
          default: begin src_x_s = SRC_T1; src_y_s = SRC_T0; dst_s = DST_Y;  last_s = 1'b1; end
        endcase
      end
      default: begin
        src_x_s = SRC_A;
        src_y_s = SRC_B;
        dst_s   = DST_Y;
        last_s  = 1'b1;
      end
    endcase
  end

  assign x_s    = pick(src_x_s, a_r[bit_r], b_r[bit_r], t0_r, t1_r);
  assign z_s    = pick(src_y_s, a_r[bit_r], b_r[bit_r], t0_r, t1_r);
  assign nand_s = nand2(x_s, z_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = op_legal(op) ? EXEC : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (last_s && (bit_r == LAST_BIT)) begin
          state_s = DONE;
        end else begin
          state_s = EXEC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand latch, scratch registers, bit/step sequencing and result bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= 3'd0;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      y_r    <= {WIDTH{1'b0}};
      err_r  <= 1'b0;
      t0_r   <= 1'b0;
      t1_r   <= 1'b0;
      bit_r  <= {BW{1'b0}};
      step_r <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r   <= op;
            a_r    <= a;
            b_r    <= b;
            y_r    <= {WIDTH{1'b0}};
            bit_r  <= {BW{1'b0}};
            step_r <= 2'd0;
            err_r  <= ~op_legal(op);
          end
        end
        EXEC: begin
          case (dst_s)
            DST_T0:  t0_r <= nand_s;
            DST_T1:  t1_r <= nand_s;
            default: y_r[bit_r] <= nand_s;
          endcase
          if (last_s) begin
            step_r <= 2'd0;
            bit_r  <= bit_r + BW'(1'b1);
          end else begin
            step_r <= step_r + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            err_r <= 1'b0;
          end
        end
        default: begin
          step_r <= 2'd0;
        end
      endcase
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      EXEC:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign y   = y_r;
  assign err = err_r;

endmodule

// File: doc/nand_serial_logic_unit.md
# nand_serial_logic_unit

Bit-serial logic unit that evaluates NAND, NOT, AND, OR, NOR and XOR on WIDTH-bit operands using one shared 2-input NAND evaluator. The evaluator is time-multiplexed across micro-steps, rebuilding each derived gate from NAND one step per clock. The block sits beside the NAND-derived gate library as its sequenced, area-minimal counterpart. It uses valid/ready handshakes on input and output.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1 to 64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; high exactly when state is IDLE.
- op  in  3  0 NAND, 1 NOT (uses a only), 2 AND, 3 OR, 4 NOR, 5 XOR; 6 and 7 are illegal.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result present; high exactly in state DONE.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result; stable while out_valid is high.
- err  out  1  illegal op flag, qualified by out_valid.
- busy  out  1  high in EXEC.

## Operation
- States: IDLE, EXEC, DONE.
- Reset forces state to IDLE. Reset values: y=0, err=0, out_valid=0, busy=0, scratch registers t0 and t1 = 0, bit and step counters = 0.
- IDLE, with in_valid=1 (accept edge):
  - Latch op, a, b.
  - Clear y, bit and step.
  - Legal op: go to EXEC.
  - Illegal op: set err=1, keep y=0 and go directly to DONE.
- EXEC performs one NAND evaluation per cycle on bit i of the latched operands (LSB first). Micro-programs, with n(x,y) = NAND:
  - NAND: y[i]=n(a,b).
  - NOT: y[i]=n(a,a).
  - AND: t0=n(a,b); y[i]=n(t0,t0).
  - OR: t0=n(a,a); t1=n(b,b); y[i]=n(t0,t1).
  - NOR: t0=n(a,a); t1=n(b,b); t0=n(t0,t1); y[i]=n(t0,t0).
  - XOR: t0=n(a,b); t1=n(a,t0); t0=n(b,t0); y[i]=n(t1,t0).
- Step count S(op): NAND 1, NOT 1, AND 2, OR 3, NOR 4, XOR 4.
- Step sequencing:
  - The last step of a bit writes y[i], resets step to 0 and increments bit.
  - The last step of bit WIDTH-1 transitions to DONE.
- DONE, with out_ready=1: go to IDLE and clear err.
- Only the single NAND evaluator may compute. No other logic operators are permitted in the datapath; muxes and registers are allowed.
- Inputs op/a/b changing after acceptance have no effect.
- in_valid while in_ready=0 is ignored; the requester must hold it.
- out_ready while out_valid=0 is ignored.
- Counter widths: bit is clog2(WIDTH) bits (minimum 1); step is 2 bits.

## Timing
- Accept edge = edge where in_valid=1 and in_ready=1.
- Legal op: out_valid rises after the accept edge plus WIDTH*S(op) EXEC edges. Example for WIDTH=8: XOR is 32 cycles, NOT is 8 cycles.
- Illegal op: out_valid high on the cycle following the accept edge.
- The DONE-to-IDLE edge occurs when out_ready=1. in_ready is high the following cycle. There is no same-cycle turnaround: back-to-back accepts are separated by at least one IDLE cycle.
- y is written bit by bit during EXEC and is meaningful only when out_valid=1. y and err stay constant for every cycle that out_valid is high.
- Asynchronous reset mid-EXEC or mid-DONE:
  - Outputs go to reset values immediately.
  - The in-flight result is discarded; no out_valid pulse occurs.
  - in_ready is high from the first cycle after reset deasserts.
- WIDTH=1: the last bit is the first bit, so latency equals S(op).

## Test plan
- XOR, WIDTH=8, a=0xA5, b=0x3C -> y=0x99, err=0, out_valid exactly 32 cycles after accept; busy high for those 32 cycles.
- AND a=0xF0, b=0x3C -> y=0x30 after 16 cycles. OR on the same operands -> y=0xFC after 24 cycles. NOR a=0x0F, b=0x30 -> y=0xC0 after 32 cycles. NOT a=0x5A -> y=0xA5 after 8 cycles. NAND a=0xFF, b=0x0F -> y=0xF0 after 8 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> y and out_valid stable, in_ready=0. Toggling in_valid/a/b during DONE -> no change in y. On the release edge -> IDLE.
- Illegal op=7 -> out_valid on the next cycle with err=1, y=0. The following legal request completes with err=0.
- Assert rst at EXEC cycle 10 of an XOR -> out_valid, busy, y, err all 0 immediately. After release, in_ready=1. A new AND a=0xFF, b=0xFF returns 0xFF after 16 cycles.
- Randomized regression against a golden model, all ops, with WIDTH=1 and WIDTH=13 builds -> results and latencies match WIDTH*S(op).
